// File: rtl/key_change_scheduler.sv
// Periodic key-rotation scheduler: prescaled seconds timebase, level key request
// with busy masking and ack handshake, active key index and a sticky overrun flag.
module key_change_scheduler #(
    parameter  int CLK_FREQ         = 1000000,
    parameter  int KEYCHANGE_PERIOD = 5,
    parameter  int NUM_KEYS         = 8,
    localparam int IDX_W            = $clog2(NUM_KEYS)
) (
    input  logic             sys_clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             busy,
    input  logic             key_ack,
    input  logic             force_change,
    input  logic             clr_overrun,
    output logic             key_req,
    output logic [IDX_W-1:0] key_index,
    output logic             key_changed,
    output logic [7:0]       sec_left,
    output logic             overrun
);

    localparam int                CNT_W      = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam logic [CNT_W-1:0]  CYC_LAST   = CNT_W'(CLK_FREQ - 1);
    localparam logic [7:0]        SEC_RELOAD = 8'(KEYCHANGE_PERIOD);
    localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(NUM_KEYS - 1);

    typedef enum logic {IDLE, PENDING} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cyc_cnt;
    logic             wrap, expiry, ack, force_go, ovr_set;

    always_comb begin
        wrap     = enable && (cyc_cnt == CYC_LAST);
        expiry   = wrap && (sec_left == 8'd1);
        ack      = key_req && key_ack;
        force_go = enable && force_change;
        // A force landing on an expiry edge merges into one request, never an overrun.
        ovr_set  = expiry && (state == PENDING) && !ack && !force_go;
        state_nxt = state;
        if (expiry || force_go)
            state_nxt = PENDING;
        else if (ack)
            state_nxt = IDLE;
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state       <= IDLE;
            cyc_cnt     <= '0;
            sec_left    <= SEC_RELOAD;
            key_index   <= '0;
            key_changed <= 1'b0;
            overrun     <= 1'b0;
            key_req     <= 1'b0;
        end else begin
            // Timebase runs freely; it never waits on the handshake.
            if (!enable || force_go) begin
                cyc_cnt  <= '0;
                sec_left <= SEC_RELOAD;
            end else if (wrap) begin
                cyc_cnt  <= '0;
                sec_left <= (sec_left == 8'd1) ? SEC_RELOAD : sec_left - 8'd1;
            end else begin
                cyc_cnt  <= cyc_cnt + 1'b1;
            end

            state       <= state_nxt;
            key_req     <= (state_nxt == PENDING) && !busy;
            key_changed <= ack;

            if (ack)
                key_index <= (key_index == IDX_LAST) ? '0 : key_index + 1'b1;

            if (ovr_set)
                overrun <= 1'b1;
            else if (clr_overrun)
                overrun <= 1'b0;
        end
    end

endmodule
